// File: rtl/dmem_pipe.sv
// Pipelined RV32I data memory for the MEM stage: valid/ready request port, 1- or 2-cycle
// registered response, fault reporting and optional split handling of misaligned accesses.
module dmem_pipe #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned READ_LAT      = 1,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_I,
  output logic        req_ready_O,
  input  logic        req_write_I,
  input  logic [2:0]  funct3_I,
  input  logic [31:0] address_I,
  input  logic [31:0] wrData_I,
  output logic        rsp_valid_O,
  output logic [31:0] rsp_data_O,
  output logic [1:0]  rsp_fault_O
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  state_e      state_q;
  logic        ready_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Second-half context of a split access
  logic            sp_write_q;
  logic [2:0]      sp_f3_q;
  logic [1:0]      sp_lane_q;
  logic [IdxW-1:0] sp_idx_q;
  logic [3:0]      sp_be_q;
  logic [31:0]     sp_wd_q;
  logic [31:0]     sp_lo_q;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_data_q, s1_data_d;
  logic [1:0]  s1_fault_q, s1_fault_d;

  logic [1:0]      lane;
  logic [29:0]     word_idx;
  logic            illegal;
  logic            misaligned;
  logic            want_split;
  logic            out_of_range;
  logic [1:0]      req_fault;
  logic            accept;
  logic            go_split;
  logic [3:0]      be_base;
  logic [7:0]      be8;
  logic [63:0]     wd64;
  logic [IdxW-1:0] rd_idx;
  logic [31:0]     rd_word;
  logic            wr_en;
  logic [IdxW-1:0] wr_idx;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;

  // Select the addressed bytes out of a two-word window and extend per funct3.
  function automatic logic [31:0] extract(logic [63:0] pair, logic [1:0] byte_off,
                                          logic [2:0] fn3);
    logic [31:0] w;
    w = 32'(pair >> {byte_off, 3'b000});
    case (fn3[1:0])
      2'b00:   extract = {{24{w[7] & ~fn3[2]}}, w[7:0]};
      2'b01:   extract = {{16{w[15] & ~fn3[2]}}, w[15:0]};
      default: extract = w;
    endcase
  endfunction

  assign req_ready_O = ready_q;

  always_comb begin
    lane       = address_I[1:0];
    word_idx   = address_I[31:2];
    illegal    = (funct3_I inside {3'b011, 3'b110, 3'b111}) || (req_write_I && funct3_I[2]);
    case (funct3_I[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    want_split   = misaligned && !MISALIGN_TRAP;
    out_of_range = (32'(word_idx) >= DEPTH_WORDS) ||
                   (want_split && ((32'(word_idx) + 32'd1) >= DEPTH_WORDS));
    if (illegal) begin
      req_fault = 2'b11;
    end else if (out_of_range) begin
      req_fault = 2'b10;
    end else if (misaligned && MISALIGN_TRAP) begin
      req_fault = 2'b01;
    end else begin
      req_fault = 2'b00;
    end
    accept   = req_valid_I && ready_q && !rst;
    go_split = accept && want_split && (req_fault == 2'b00);
  end

  // Byte enables and data laid over a two-word window; the upper word only matters when split.
  always_comb begin
    case (funct3_I[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be8  = {4'b0000, be_base} << lane;
    wd64 = {32'h0, wrData_I} << {lane, 3'b000};
  end

  always_comb begin
    rd_idx  = (state_q == StSplit) ? sp_idx_q : word_idx[IdxW-1:0];
    rd_word = mem[rd_idx];
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx[IdxW-1:0];
    wr_be   = be8[3:0];
    wr_data = wd64[31:0];
    if (state_q == StSplit) begin
      wr_en   = sp_write_q && !rst;
      wr_idx  = sp_idx_q;
      wr_be   = sp_be_q;
      wr_data = sp_wd_q;
    end else begin
      wr_en = accept && req_write_I && (req_fault == 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = 1'b0;
    s1_fault_d = 2'b00;
    s1_data_d  = 32'h0;
    if (state_q == StSplit) begin
      s1_valid_d = 1'b1;
      s1_data_d  = sp_write_q ? 32'h0 : extract({rd_word, sp_lo_q}, sp_lane_q, sp_f3_q);
    end else if (accept && !go_split) begin
      s1_valid_d = 1'b1;
      s1_fault_d = req_fault;
      if (!req_write_I && (req_fault == 2'b00)) begin
        s1_data_d = extract({32'h0, rd_word}, lane, funct3_I);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ready_q    <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'h0;
      s1_fault_q <= 2'b00;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_fault_q <= s1_fault_d;
      unique case (state_q)
        StIdle: begin
          if (go_split) begin
            state_q    <= StSplit;
            ready_q    <= 1'b0;
            sp_write_q <= req_write_I;
            sp_f3_q    <= funct3_I;
            sp_lane_q  <= lane;
            sp_idx_q   <= IdxW'(32'(word_idx) + 32'd1);
            sp_be_q    <= be8[7:4];
            sp_wd_q    <= wd64[63:32];
            sp_lo_q    <= rd_word;
          end
        end
        StSplit: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        s2_valid_q;
      logic [31:0] s2_data_q;
      logic [1:0]  s2_fault_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= 32'h0;
          s2_fault_q <= 2'b00;
        end else begin
          s2_valid_q <= s1_valid_q;
          s2_data_q  <= s1_data_q;
          s2_fault_q <= s1_fault_q;
        end
      end

      assign rsp_valid_O = s2_valid_q;
      assign rsp_data_O  = s2_data_q;
      assign rsp_fault_O = s2_fault_q;
    end else begin : g_lat1
      assign rsp_valid_O = s1_valid_q;
      assign rsp_data_O  = s1_data_q;
      assign rsp_fault_O = s1_fault_q;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: a trapping 1-cycle instance and a splitting 2-cycle instance share one
// request stream; a byte-level reference model predicts every response and ready cycle.
module tb_dmem_pipe;

  localparam int unsigned D = 64;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic req_write;
  logic [2:0] funct3;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [1:0]       rdy;
  logic [1:0]       rv;
  logic [1:0][31:0] rd;
  logic [1:0][1:0]  rf;

  always #5 clk = ~clk;

  dmem_pipe #(.DEPTH_WORDS(D), .READ_LAT(1), .MISALIGN_TRAP(1'b1)) u_trap (
    .clk(clk), .rst(rst), .req_valid_I(req_valid), .req_ready_O(rdy[0]),
    .req_write_I(req_write), .funct3_I(funct3), .address_I(addr), .wrData_I(wdata),
    .rsp_valid_O(rv[0]), .rsp_data_O(rd[0]), .rsp_fault_O(rf[0])
  );

  dmem_pipe #(.DEPTH_WORDS(D), .READ_LAT(2), .MISALIGN_TRAP(1'b0)) u_split (
    .clk(clk), .rst(rst), .req_valid_I(req_valid), .req_ready_O(rdy[1]),
    .req_write_I(req_write), .funct3_I(funct3), .address_I(addr), .wrData_I(wdata),
    .rsp_valid_O(rv[1]), .rsp_data_O(rd[1]), .rsp_fault_O(rf[1])
  );

  // Instance k: trap = (k == 0), latency = k + 1.
  logic [7:0]  mb    [2][4*D];
  bit          exp_v [2][8];
  logic [31:0] exp_d [2][8];
  logic [1:0]  exp_f [2][8];
  bit          mrdy  [2];
  bit          pend  [2];
  logic [31:0] p_addr [2];
  logic [2:0]  p_f3   [2];
  bit          p_w    [2];
  logic [31:0] p_wd   [2];
  logic [31:0] last_d [2];
  logic [1:0]  last_f [2];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s inst%0d cyc%0d got %h expected %h", tag, k, cyc, got, want);
    end
  endtask

  function automatic int size_of(logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(int k, logic [31:0] a, logic [2:0] f);
    logic [31:0] v;
    int sz;
    sz = size_of(f);
    v = 32'h0;
    for (int b = 0; b < sz; b++) v[8*b +: 8] = mb[k][int'(a) + b];
    if (sz == 1) return f[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (sz == 2) return f[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] init_word(int i);
    return 32'h5A5A5A5A ^ (32'(i) * 32'h01030507);
  endfunction

  task automatic sched(int k, logic [1:0] f, logic [31:0] d);
    int s;
    s = (cyc + k) % 8;
    exp_v[k][s] = 1'b1;
    exp_d[k][s] = d;
    exp_f[k][s] = f;
  endtask

  task automatic new_req(int k);
    int sz;
    bit ill, mis, spl, oor;
    logic [31:0] idx, d;
    logic [1:0] flt;
    sz  = size_of(funct3);
    ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) || (req_write && funct3[2]);
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    spl = mis && (k == 1);
    idx = addr >> 2;
    oor = (idx >= D) || (spl && (idx + 1 >= D));
    flt = ill ? 2'd3 : oor ? 2'd2 : (mis && k == 0) ? 2'd1 : 2'd0;
    if (flt == 2'd0 && spl) begin
      if (req_write)
        for (int b = 0; b < sz; b++)
          if (((addr + 32'(b)) >> 2) == idx) mb[k][int'(addr) + b] = wdata[8*b +: 8];
      pend[k] = 1'b1; mrdy[k] = 1'b0;
      p_addr[k] = addr; p_f3[k] = funct3; p_w[k] = req_write; p_wd[k] = wdata;
    end else begin
      d = 32'h0;
      if (flt == 2'd0) begin
        if (req_write) for (int b = 0; b < sz; b++) mb[k][int'(addr) + b] = wdata[8*b +: 8];
        else d = load_val(k, addr, funct3);
      end
      sched(k, flt, d);
    end
  endtask

  task automatic finish_split(int k);
    int sz;
    logic [31:0] d;
    sz = size_of(p_f3[k]);
    if (p_w[k])
      for (int b = 0; b < sz; b++)
        if (((p_addr[k] + 32'(b)) >> 2) != (p_addr[k] >> 2))
          mb[k][int'(p_addr[k]) + b] = p_wd[k][8*b +: 8];
    d = p_w[k] ? 32'h0 : load_val(k, p_addr[k], p_f3[k]);
    sched(k, 2'd0, d);
    pend[k] = 1'b0;
    mrdy[k] = 1'b1;
  endtask

  task automatic tick();
    int s;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int j = 0; j < 8; j++) exp_v[k][j] = 1'b0;
        pend[k] = 1'b0;
        mrdy[k] = 1'b1;
      end else if (pend[k]) begin
        finish_split(k);
      end else if (req_valid && mrdy[k]) begin
        new_req(k);
      end
    end
    #1;
    s = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      chk("rsp_valid", k, {31'h0, rv[k]}, {31'h0, exp_v[k][s]});
      if (exp_v[k][s]) begin
        chk("rsp_data", k, rd[k], exp_d[k][s]);
        chk("rsp_fault", k, {30'h0, rf[k]}, {30'h0, exp_f[k][s]});
      end
      if (rv[k] === 1'b1) begin
        last_d[k] = rd[k];
        last_f[k] = rf[k];
      end
      chk("req_ready", k, {31'h0, rdy[k]}, {31'h0, mrdy[k]});
      exp_v[k][s] = 1'b0;
    end
  endtask

  task automatic issue(bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    last_d[0] = 'x; last_d[1] = 'x; last_f[0] = 'x; last_f[1] = 'x;
    req_valid = 1'b1; req_write = w; funct3 = f; addr = a; wdata = d;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic expect_k(string tag, int k, logic [31:0] d, logic [1:0] f);
    chk(tag, k, last_d[k], d);
    chk({tag, "_fault"}, k, {30'h0, last_f[k]}, {30'h0, f});
  endtask

  initial begin
    logic [31:0] w6;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("reset_data", k, rd[k], 32'h0);
      chk("reset_fault", k, {30'h0, rf[k]}, 32'h0);
      chk("reset_ready", k, {31'h0, rdy[k]}, 32'h1);
    end

    // Fill every word back-to-back
    for (int i = 0; i < int'(D); i++) begin
      req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'(4 * i); wdata = init_word(i);
      tick();
    end
    req_valid = 1'b0;
    tick(); tick(); tick();

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("lb", k, 32'hFFFFFFDE, 2'd0);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("lbu", k, 32'h000000DE, 2'd0);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("lh", k, 32'hFFFFDEAD, 2'd0);
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("lhu", k, 32'h0000DEAD, 2'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("lw", k, 32'hDEADBEEF, 2'd0);

    issue(1'b1, 3'b010, 32'h20, 32'h0);
    issue(1'b1, 3'b001, 32'h22, 32'h1234);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("sh_hi", k, 32'h12340000, 2'd0);
    issue(1'b1, 3'b000, 32'h21, 32'hAA);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("sb_lane1", k, 32'h1234AA00, 2'd0);

    issue(1'b1, 3'b010, 32'h04, 32'h11223344);
    issue(1'b1, 3'b010, 32'h08, 32'h55667788);
    issue(1'b0, 3'b010, 32'h05, 32'h0);
    expect_k("lw_mis_trap", 0, 32'h0, 2'd1);
    expect_k("lw_mis_split", 1, 32'h88112233, 2'd0);
    issue(1'b1, 3'b010, 32'h05, 32'hCAFEF00D);
    expect_k("sw_mis_trap", 0, 32'h0, 2'd1);
    issue(1'b0, 3'b010, 32'h04, 32'h0);
    expect_k("no_write_trap", 0, 32'h11223344, 2'd0);
    expect_k("split_write", 1, 32'hFEF00D44, 2'd0);

    issue(1'b1, 3'b010, 32'h0C, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'h0E; wdata = 32'hA1B2C3D4;
    tick();
    req_valid = 1'b0;
    chk("split_ready_low", 1, {31'h0, rdy[1]}, 32'h0);
    chk("trap_ready_high", 0, {31'h0, rdy[0]}, 32'h1);
    tick(); tick(); tick();
    issue(1'b0, 3'b010, 32'h0E, 32'h0);
    expect_k("lw_0e_trap", 0, 32'h0, 2'd1);
    expect_k("lw_0e_split", 1, 32'hA1B2C3D4, 2'd0);
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    expect_k("word3_trap", 0, 32'h0, 2'd0);
    expect_k("word3_split", 1, 32'hC3D40000, 2'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    expect_k("word4_trap", 0, 32'hDEADBEEF, 2'd0);
    expect_k("word4_split", 1, 32'hDEADA1B2, 2'd0);

    issue(1'b0, 3'b010, 32'(4 * D), 32'h0);
    for (int k = 0; k < 2; k++) expect_k("lw_oor", k, 32'h0, 2'd2);
    issue(1'b0, 3'b001, 32'(4 * D - 1), 32'h0);
    expect_k("lh_top_trap", 0, 32'h0, 2'd1);
    expect_k("lh_top_split", 1, 32'h0, 2'd2);
    issue(1'b1, 3'b001, 32'(4 * D - 1), 32'hBEEF);
    expect_k("sh_top_split", 1, 32'h0, 2'd2);
    issue(1'b0, 3'b010, 32'(4 * D - 4), 32'h0);
    for (int k = 0; k < 2; k++) expect_k("top_unchanged", k, init_word(int'(D) - 1), 2'd0);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("f3_011", k, 32'h0, 2'd3);
    issue(1'b1, 3'b101, 32'h10, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("shu_illegal", k, 32'h0, 2'd3);

    // Reset lands on the SPLIT cycle of a misaligned store
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'h1A; wdata = 32'h99887766;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) chk("ready_after_rst", k, {31'h0, rdy[k]}, 32'h1);
    tick(); tick(); tick();
    w6 = init_word(6);
    issue(1'b0, 3'b010, 32'h18, 32'h0);
    expect_k("rst_split_first", 1, {16'h7766, w6[15:0]}, 2'd0);
    expect_k("rst_trap_word6", 0, w6, 2'd0);
    issue(1'b0, 3'b010, 32'h1C, 32'h0);
    for (int k = 0; k < 2; k++) expect_k("rst_split_second", k, init_word(7), 2'd0);

    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(7));
      rst       = ($urandom_range(99) == 0);
      req_valid = ($urandom_range(3) != 0);
      req_write = 1'($urandom_range(1));
      funct3    = 3'($urandom_range(7));
      wdata     = $urandom;
      if (r == 0) addr = 32'(4 * D - 16) + 32'($urandom_range(31));
      else if (r == 1) addr = $urandom;
      else addr = 32'($urandom_range(63));
      tick();
    end
    rst = 1'b0; req_valid = 1'b0;
    tick(); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised successor of the single-cycle data memory; sits in the MEM stage of the RV32I pipeline behind a valid/ready request port.
- Adds a registered read path of 1 or 2 cycles, fault reporting, and out-of-range detection.
- Adds optional hardware splitting of misaligned halfword/word accesses into two word accesses, sequenced by a small FSM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; legal word index 0..DEPTH_WORDS-1.
- READ_LAT, 1, request-to-response latency for aligned accesses; legal values 1 or 2 (2 adds an output register stage).
- MISALIGN_TRAP, 1, 1 = misaligned access faults; 0 = misaligned access is split into two word accesses.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_I  in  1  request present.
- req_ready_O  out  1  request accepted when req_valid_I && req_ready_O.
- req_write_I  in  1  1 = store, 0 = load.
- funct3_I  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- address_I  in  32  byte address.
- wrData_I  in  32  store data, right-aligned.
- rsp_valid_O  out  1  one-cycle response pulse; one per accepted request, loads and stores alike.
- rsp_data_O  out  32  load result, sign- or zero-extended; 0 for stores and faults.
- rsp_fault_O  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - rsp_valid_O=0, rsp_data_O=0, rsp_fault_O=0.
  - FSM goes to IDLE; req_ready_O=1 in the first cycle after rst deasserts.
  - Memory contents are not reset.
- Word index: address_I[31:2]. Byte lane: address_I[1:0].
- Misaligned definition: h/hu with addr[0]=1; w with addr[1:0]!=00. Byte accesses are never misaligned.
- Illegal funct3: 011, 110, 111 for any access; 100 and 101 for stores.
- Fault priority: illegal > out of range > misaligned.
  - Out of range is checked on the word index, and on index+1 when the access will be split.
  - A faulting access has no memory side effect: no write, rsp_data_O=0.
  - The response keeps normal timing: the fault response for a would-be split access returns at the aligned latency.
- Stores update only the addressed bytes:
  - sh with addr[1]=1 writes bits 31:16; addr[1]=0 writes bits 15:0.
  - sb writes lane addr[1:0].
- Memory writes commit at the rising edge that accepts the request.
  - A load accepted on the next cycle to the same word returns the new data; no forwarding logic is needed.
- Aligned access accepted at edge N: rsp_valid_O is high in the cycle after edge N+READ_LAT-1, i.e. latency READ_LAT. Back-to-back acceptance every cycle is supported.
- FSM states:
  - IDLE: req_ready_O=1.
    - Aligned or faulting request -> stay IDLE.
    - Misaligned, in-range request with MISALIGN_TRAP=0 -> SPLIT. On this first access, write or capture the bytes in word W.
  - SPLIT: req_ready_O=0 for exactly one cycle.
    - Second access handles the remaining bytes in word W+1.
    - Load: merge the captured low bytes with the high bytes, then extend per funct3.
    - -> IDLE.
- Split access latency: READ_LAT+1. Only one rsp_valid_O pulse is issued for a split access.
- No response backpressure: the consumer must always accept rsp_valid_O.
- rst asserted in SPLIT:
  - The second half is abandoned and no response is issued.
  - The first-half store bytes stay committed (documented partial store).
  - Responses pending in the output pipeline are dropped.
- Stores with funct3 bu/hu are illegal. Load funct3 011 returns fault 11, never data.

Test Plan:
- sw 0xDEADBEEF @0x10, then lb/lbu/lh/lhu/lw @0x13/0x13/0x12/0x12/0x10 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF; each returns READ_LAT cycles after acceptance.
- sh 0x1234 @0x22 over word 0 -> word 0x12340000; then sb 0xAA @0x21 -> 0x1234AA00.
- MISALIGN_TRAP=1, lw @0x05 -> rsp_fault_O=01, rsp_data_O=0; a following sw @0x05 leaves memory unchanged.
- MISALIGN_TRAP=0, sw 0xA1B2C3D4 @0x0E, lw @0x0E:
  - req_ready_O is low for one cycle after each request.
  - word 3 bits 31:16 = 0xC3D4; word 4 bits 15:0 = 0xA1B2.
  - Load returns 0xA1B2C3D4 at READ_LAT+1.
- lw @4*DEPTH_WORDS -> fault 10. With MISALIGN_TRAP=0, lh @4*DEPTH_WORDS-1 -> fault 10 and no write. funct3=011 -> fault 11.
- Assert rst during SPLIT of a misaligned sw:
  - no rsp_valid_O pulse is issued.
  - first word is updated; second word is unchanged.
  - req_ready_O=1 in the first cycle after rst deasserts.
